exec_ctrl: RTL and testbench

Execution controller for the 8-bit accumulator CPU. It produces the single clock enable `cpu_ce` that gates every CPU state element: pc, stack, reg_file, mem_bank_reg, mem write, acc and flags. It implements run, halt and single-step, plus one hardware breakpoint on the instruction pointer and halt-on-HLT-instruction. It also keeps a retired-instruction counter for the debug display.

---
 rtl/exec_ctrl.sv | 114 +++++++++++
 tb/tb_exec_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exec_ctrl
// Brief    : Run/halt/single-step execution controller with IP breakpoint,
//            halt-on-HLT and a saturating retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module exec_ctrl #(
  parameter int AW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic             bp_en,
  input  logic [AW-1:0]    bp_addr,
  input  logic [AW-1:0]    ip,
  input  logic             halt_inst,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_HALTED  = 2'd0,
    S_RUNNING = 2'd1,
    S_STEP    = 2'd2,
    S_BREAK   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               skip_bp_q, skip_bp_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               run_q, halt_q, step_q;
  logic               run_e, halt_e, step_e;
  logic               bp_match;
  logic               ce_d;

  assign run_e    = cmd_run  & ~run_q;
  assign halt_e   = cmd_halt & ~halt_q;
  assign step_e   = cmd_step & ~step_q;
  assign bp_match = bp_en & (ip == bp_addr) & ~skip_bp_q;

  always_comb begin
    state_d   = state_q;
    skip_bp_d = skip_bp_q;
    ce_d      = 1'b0;
    case (state_q)
      S_HALTED, S_BREAK: begin
        if (step_e) begin
          state_d = S_STEP;
        end else if (run_e) begin
          state_d   = S_RUNNING;
          skip_bp_d = 1'b1;
        end
      end
      S_RUNNING: begin
        ce_d = ~bp_match & ~halt_inst & ~halt_e;
        // Any exit, or the first executed instruction, re-arms the breakpoint.
        if (bp_match) begin
          state_d   = S_BREAK;
          skip_bp_d = 1'b0;
        end else if (halt_inst || halt_e) begin
          state_d   = S_HALTED;
          skip_bp_d = 1'b0;
        end else if (ce_d) begin
          skip_bp_d = 1'b0;
        end
      end
      S_STEP: begin
        ce_d      = ~halt_inst;
        state_d   = S_HALTED;
        skip_bp_d = 1'b0;
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (ce_d && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + 1'b1;
    end
  end

  // Edge history resets high so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HALTED;
      skip_bp_q <= 1'b0;
      retired_q <= '0;
      run_q     <= 1'b1;
      halt_q    <= 1'b1;
      step_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      skip_bp_q <= skip_bp_d;
      retired_q <= retired_d;
      run_q     <= cmd_run;
      halt_q    <= cmd_halt;
      step_q    <= cmd_step;
    end
  end

  assign cpu_ce  = ce_d;
  assign state   = state_q;
  assign bp_hit  = (state_q == S_BREAK);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_ctrl
// Brief    : Self-checking bench for exec_ctrl; directed scenarios followed by
//            randomized commands against a behavioural CPU/controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_ctrl;

  localparam int AW    = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_run, cmd_halt, cmd_step;
  logic             bp_en;
  logic [AW-1:0]    bp_addr;
  logic [AW-1:0]    ip;
  logic             halt_inst;
  logic             cpu_ce;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] retired;

  exec_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_run   (cmd_run),
    .cmd_halt  (cmd_halt),
    .cmd_step  (cmd_step),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .ip        (ip),
    .halt_inst (halt_inst),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .bp_hit    (bp_hit),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // Tiny program: 16 slots, each with an HLT flag and a successor address.
  logic       hlt_mem [16];
  logic [7:0] nxt_mem [16];
  assign halt_inst = hlt_mem[ip[3:0]];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 halted, 1 running, 2 step, 3 break.
  int m_state, m_ret;
  bit m_skip, p_run, p_halt, p_step;
  int s_ret, s_state, s_bp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    bit run_e, halt_e, step_e, hlt, bpm, ce;
    int ns;
    @(negedge clk);
    #1;
    hlt    = hlt_mem[ip[3:0]];
    run_e  = cmd_run  && !p_run;
    halt_e = cmd_halt && !p_halt;
    step_e = cmd_step && !p_step;
    bpm    = bp_en && (ip == bp_addr) && !m_skip;
    ce     = (m_state == 1) ? (!bpm && !hlt && !halt_e) :
             (m_state == 2) ? !hlt : 1'b0;
    chk("cpu_ce",  32'(cpu_ce),  32'(ce));
    chk("state",   32'(state),   32'(m_state));
    chk("bp_hit",  32'(bp_hit),  32'(m_state == 3));
    chk("retired", 32'(retired), 32'(m_ret));
    s_ret   = int'(retired);
    s_state = int'(state);
    s_bp    = int'(bp_hit);
    @(posedge clk);
    #1;
    if (rst) begin
      m_state = 0; m_skip = 0; m_ret = 0;
      p_run = 1; p_halt = 1; p_step = 1;
      ip = '0;
    end else begin
      case (m_state)
        1:       ns = bpm ? 3 : ((hlt || halt_e) ? 0 : 1);
        2:       ns = 0;
        default: ns = step_e ? 2 : (run_e ? 1 : m_state);
      endcase
      if (ns == 1 && m_state != 1)                m_skip = 1;
      else if (m_state == 1 && (ns != 1 || ce))   m_skip = 0;
      if (ce) begin
        m_ret = (m_ret == CMAX) ? CMAX : m_ret + 1;
        ip    = nxt_mem[ip[3:0]];
      end
      m_state = ns;
      p_run = cmd_run; p_halt = cmd_halt; p_step = cmd_step;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic linear_prog();
    for (int i = 0; i < 16; i++) begin
      hlt_mem[i] = 1'b0;
      nxt_mem[i] = 8'((i + 1) % 16);
    end
  endtask

  task automatic random_prog();
    for (int i = 0; i < 16; i++) begin
      hlt_mem[i] = ($urandom % 10) == 0;
      nxt_mem[i] = (($urandom % 6) == 0) ? 8'($urandom % 16) : 8'((i + 1) % 16);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_run = 0; cmd_halt = 0; cmd_step = 0;
    bp_en = 0; bp_addr = '0; ip = '0;
    linear_prog();
    repeat (2) @(posedge clk);
    #1;
    m_state = 0; m_skip = 0; m_ret = 0;
    p_run = 1; p_halt = 1; p_step = 1;
    rst = 1'b0;
    cycle();

    // Run from reset, no re-trigger while held; ten executed instructions.
    cmd_run = 1; repeat (3) cycle();
    cmd_run = 0; repeat (9) cycle();
    chk("run_retired10", 32'(s_ret), 32'd10);
    chk("run_state", 32'(s_state), 32'd1);

    // Breakpoint at 0x05, resume executes it once, loop back re-breaks.
    bp_en = 1; bp_addr = 8'h05;
    do_reset();
    cmd_run = 1; cycle();
    cmd_run = 0; repeat (7) cycle();
    chk("bp_hit", 32'(s_bp), 32'd1);
    chk("bp_retired5", 32'(s_ret), 32'd5);
    cmd_run = 1; cycle();
    cmd_run = 0; repeat (20) cycle();
    chk("bp_rebreak", 32'(s_state), 32'd3);
    chk("bp_retired21", 32'(s_ret), 32'd21);

    // HLT at 0x07: not executed, step on HLT executes nothing.
    bp_en = 0; hlt_mem[7] = 1'b1;
    do_reset();
    cmd_run = 1; cycle();
    cmd_run = 0; repeat (9) cycle();
    chk("hlt_state", 32'(s_state), 32'd0);
    chk("hlt_retired7", 32'(s_ret), 32'd7);
    cmd_step = 1; cycle();
    cmd_step = 0; repeat (2) cycle();
    chk("hlt_step_retired", 32'(s_ret), 32'd7);

    // Simultaneous step and run edges: step wins.
    do_reset();
    cmd_run = 1; cmd_step = 1; cycle();
    cmd_run = 0; cmd_step = 0; cycle();
    chk("step_wins", 32'(s_state), 32'd2);
    cycle();
    chk("step_one", 32'(s_ret), 32'd1);

    // Halt edge coinciding with breakpoint match goes to BREAK.
    bp_en = 1; bp_addr = 8'h03;
    do_reset();
    cmd_run = 1; cycle();
    cmd_run = 0; repeat (3) cycle();
    cmd_halt = 1; cycle();
    cmd_halt = 0; cycle();
    chk("halt_vs_bp", 32'(s_bp), 32'd1);

    // Reset mid-run with run held: stays halted until a fresh edge.
    bp_en = 0;
    do_reset();
    cmd_run = 1; repeat (3) cycle();
    rst = 1; cycle();
    rst = 0; repeat (3) cycle();
    chk("rst_held_state", 32'(s_state), 32'd0);
    chk("rst_held_ret", 32'(s_ret), 32'd0);
    cmd_run = 0; cycle();
    cmd_run = 1; repeat (2) cycle();
    chk("rst_rerun", 32'(s_state), 32'd1);
    cmd_run = 0;

    // Randomized commands, breakpoints, programs and occasional reset.
    for (int blk = 0; blk < 8; blk++) begin
      random_prog();
      for (int c = 0; c < 500; c++) begin
        if (($urandom % 10) == 0)  cmd_run  = ~cmd_run;
        if (($urandom % 25) == 0)  cmd_halt = ~cmd_halt;
        if (($urandom % 14) == 0)  cmd_step = ~cmd_step;
        if (($urandom % 40) == 0)  bp_en    = ~bp_en;
        if (($urandom % 30) == 0)  bp_addr  = 8'($urandom % 16);
        rst = (($urandom % 400) == 0);
        cycle();
      end
      rst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
